// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial link blocks: receiver FSM states, default
// word width, line-level framing constants and the total frame length.
// -----------------------------------------------------------------------------
package serial_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

  // Default data bits per frame.
  localparam int SER_WIDTH = 16;

  // Line levels of the framing bits. The line idles at STOP_BIT level.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Strobes per frame: start bit + data bits + stop bit.
  localparam int FRAME_LEN = SER_WIDTH + 2;

endpackage : serial_pkg

// File: rtl/sipo_register.sv
// -----------------------------------------------------------------------------
// sipo_register
// WIDTH-bit serial-in / parallel-out register shifting towards the MSB, so a
// stream sent MSB first ends up in natural bit order. Receive-side counterpart
// of the left-shifting transmit register.
//
// Ports:
//   clk   in            rising-edge clock
//   rst   in            asynchronous active-high reset (q <= 0)
//   clr   in            synchronous clear (q <= 0), has priority over sh_en
//   sh_en in            shift enable: q <= {q[WIDTH-2:0], s_in}
//   s_in  in            serial input bit
//   q     out [WIDTH]   parallel contents
// -----------------------------------------------------------------------------
module sipo_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sh_en,
  input  logic             s_in,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (sh_en) begin
      q <= {q[WIDTH-2:0], s_in};
    end
  end

endmodule : sipo_register

// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
// Receives framed serial words (start 0, WIDTH data bits MSB first, stop 1),
// one bit per ser_en strobe, and presents each good word on a held parallel
// output with a valid/ack handshake. Bad stop bits raise a one-cycle frm_err;
// a good word arriving while the previous one is unacknowledged is dropped
// and flagged on the sticky ovr.
//
// Ports:
//   clk      in            rising-edge clock
//   rst      in            asynchronous active-high reset
//   clr      in            synchronous clear, same effect as rst
//   ser_en   in            bit strobe; ser_in sampled only when high
//   ser_in   in            serial line, idles high
//   ack      in            consumer has taken data_out
//   data_out out [WIDTH]   last good word, held until replaced
//   data_vld out           data_out holds an unacknowledged word
//   frm_err  out           one-cycle pulse: stop bit was 0
//   ovr      out           sticky: good word dropped while data_vld was set
//   busy     out           frame in progress
// -----------------------------------------------------------------------------
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ser_en,
  input  logic             ser_in,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_vld,
  output logic             frm_err,
  output logic             ovr,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_q;

  logic start_det;
  logic shift_en;

  // A start bit seen in IDLE also zeroes the shift register so no bits of an
  // aborted frame can leak into the next word.
  assign start_det = (state == IDLE) && ser_en && (ser_in == START_BIT);
  assign shift_en  = (state == DATA) && ser_en;

  sipo_register #(
    .WIDTH (WIDTH)
  ) u_sipo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr | start_det),
    .sh_en (shift_en),
    .s_in  (ser_in),
    .q     (shift_q)
  );

  // NOTE: data_out is a plain register, not a memory, so it gets a reset value;
  // the consumer may look at it before the first word and must see zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      data_out <= '0;
      data_vld <= 1'b0;
      frm_err  <= 1'b0;
      ovr      <= 1'b0;
      busy     <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      data_out <= '0;
      data_vld <= 1'b0;
      frm_err  <= 1'b0;
      ovr      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      frm_err <= 1'b0;

      // Acknowledge; a word loaded later in this block on the same edge
      // overrides the data_vld clear.
      if (ack && data_vld) begin
        data_vld <= 1'b0;
        ovr      <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start_det) begin
            state   <= DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        DATA: begin
          if (ser_en) begin
            // Hold the counter on the last bit so it never wraps mid-frame.
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (ser_en) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (ser_in == STOP_BIT) begin
              if (!data_vld || ack) begin
                data_out <= shift_q;
                data_vld <= 1'b1;
              end else begin
                ovr <= 1'b1;
              end
            end else begin
              frm_err <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_word_receiver

// File: tb/tb_serial_word_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_word_receiver
// Self-checking bench: words expected at the parallel output are queued when
// their frames are sent and compared when data_vld rises.
// -----------------------------------------------------------------------------
module tb_serial_word_receiver;
  import serial_pkg::*;

  localparam int W = SER_WIDTH;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         ser_en;
  logic         ser_in;
  logic         ack;
  logic [W-1:0] data_out;
  logic         data_vld;
  logic         frm_err;
  logic         ovr;
  logic         busy;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .ser_en   (ser_en),
    .ser_in   (ser_in),
    .ack      (ack),
    .data_out (data_out),
    .data_vld (data_vld),
    .frm_err  (frm_err),
    .ovr      (ovr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard and a small reference of the handshake flags.
  logic [W-1:0] sb_q[$];
  logic         m_vld;

  // Edge counter and monitor state.
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = -1;
  int   err_cnt = 0;
  logic vld_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frm_err === 1'b1) err_cnt++;
    if (data_vld === 1'b1 && vld_d !== 1'b1) begin
      rise_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", 32'(data_out), 32'hDEAD_0000);
      end else begin
        check("sb_data_out", 32'(data_out), 32'(sb_q.pop_front()));
      end
    end
    vld_d = data_vld;
  end

  // Drives one strobed bit, then gap strobe-free cycles. Returns 1 time unit
  // after the last edge.
  task automatic send_bit(input logic b, input int gap);
    ser_in = b;
    ser_en = 1'b1;
    @(posedge clk);
    #1;
    ser_en = 1'b0;
    ser_in = 1'b1;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic stop,
                            input int gap, input logic ack_on_stop);
    send_bit(START_BIT, gap);
    start_cyc = cyc - gap;
    for (int i = W - 1; i >= 0; i--) send_bit(word[i], gap);
    if (stop == STOP_BIT) begin
      if (!m_vld || ack_on_stop) begin
        sb_q.push_back(word);
        m_vld = 1'b1;
      end
    end
    ack = ack_on_stop;
    send_bit(stop, 0);
    ack = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    if (m_vld) m_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    clr    = 1'b0;
    ser_en = 1'b0;
    ser_in = 1'b1;
    ack    = 1'b0;
    m_vld  = 1'b0;
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_vld", 32'(data_vld), 32'h0);
    check("rst_frm_err",  32'(frm_err),  32'h0);
    check("rst_ovr",      32'(ovr),      32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    do_reset();

    // 1: back-to-back strobes, latency from start edge.
    send_frame(16'hA5C3, STOP_BIT, 0, 1'b0);
    @(negedge clk);
    #1;
    check("t1_latency_edges", 32'(rise_cyc - start_cyc + 1), 32'(FRAME_LEN));
    check("t1_data_out", 32'(data_out), 32'hA5C3);
    check("t1_frm_err_cnt", 32'(err_cnt), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    pulse_ack();
    check("t1_vld_after_ack", 32'(data_vld), 32'h0);

    // 2: sparse strobes with idle-high bits before the start bit.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 2);
    check("t2_no_spurious_start", 32'(busy), 32'h0);
    send_frame(16'hA5C3, STOP_BIT, 2, 1'b0);
    @(negedge clk);
    #1;
    check("t2_data_out", 32'(data_out), 32'hA5C3);
    check("t2_data_vld", 32'(data_vld), 32'h1);

    // 3: bad stop bit from a fresh reset.
    do_reset();
    send_frame(16'h1234, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("t3_frm_err_pulse", 32'(frm_err), 32'h1);
    @(negedge clk);
    check("t3_frm_err_drop", 32'(frm_err), 32'h0);
    check("t3_frm_err_cnt", 32'(err_cnt), 32'h1);
    check("t3_data_vld", 32'(data_vld), 32'h0);
    check("t3_data_out", 32'(data_out), 32'h0);
    @(posedge clk);
    #1;

    // 4: overrun, ack clears, ack on the stop edge loads.
    send_frame(16'hFFFF, STOP_BIT, 0, 1'b0);
    send_frame(16'h0001, STOP_BIT, 0, 1'b0);
    check("t4_ovr_set", 32'(ovr), 32'h1);
    check("t4_data_out_kept", 32'(data_out), 32'hFFFF);
    pulse_ack();
    check("t4_vld_cleared", 32'(data_vld), 32'h0);
    check("t4_ovr_cleared", 32'(ovr), 32'h0);
    send_frame(16'h0001, STOP_BIT, 0, 1'b1);
    check("t4_data_out_new", 32'(data_out), 32'h0001);
    check("t4_vld_new", 32'(data_vld), 32'h1);
    check("t4_ovr_new", 32'(ovr), 32'h0);

    // 5a: rst in the middle of a frame.
    send_bit(START_BIT, 0);
    for (int i = W - 1; i >= W - 8; i--) send_bit(logic'((16'hBEEF >> i) & 1), 0);
    check("t5_busy_mid", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_vld", 32'(data_vld), 32'h0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_vld = 1'b0;
    send_frame(16'h8001, STOP_BIT, 0, 1'b0);
    @(negedge clk);
    check("t5_rst_data_out", 32'(data_out), 32'h8001);
    check("t5_rst_ovr", 32'(ovr), 32'h0);

    // 5b: same with clr.
    @(posedge clk);
    #1;
    send_bit(START_BIT, 0);
    for (int i = W - 1; i >= W - 8; i--) send_bit(logic'((16'hBEEF >> i) & 1), 0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    m_vld = 1'b0;
    check("t5_clr_busy", 32'(busy), 32'h0);
    check("t5_clr_vld", 32'(data_vld), 32'h0);
    send_frame(16'h8001, STOP_BIT, 0, 1'b0);
    @(negedge clk);
    check("t5_clr_data_out", 32'(data_out), 32'h8001);
    check("t5_clr_ovr", 32'(ovr), 32'h0);
    check("t5_frm_err_cnt", 32'(err_cnt), 32'h1);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serial_word_receiver

// File: doc/serial_word_receiver.md
# serial_word_receiver

Receive-side partner of the team's 16-bit left-shifting transmit register: it accepts a framed serial bit stream, MSB first, one bit per `ser_en` strobe. It assembles each word in an internal serial-in/parallel-out register, checks framing, and presents the word on a held parallel output with a valid/ack handshake. It sits between the serial link and the datapath consumer.

## Interface
- `WIDTH`, default 16: data bits per frame.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `clr`  in  1  synchronous clear. Same effect as `rst`, applied at the clock edge.
- `ser_en`  in  1  bit strobe. `ser_in` is sampled only on edges where `ser_en`=1.
- `ser_in`  in  1  serial line. Idles high.
- `ack`  in  1  consumer has taken `data_out`.
- `data_out`  out  WIDTH  last good word. Held until it is replaced.
- `data_vld`  out  1  `data_out` holds an unacknowledged word.
- `frm_err`  out  1  one-cycle pulse: the stop bit was 0.
- `ovr`  out  1  sticky flag: a good word was dropped because `data_vld` was still set.
- `busy`  out  1  a frame is in progress (state != IDLE).

## Operation
- **Frame format:** start bit (0), then WIDTH data bits MSB first, then stop bit (1). That is WIDTH+2 strobes in total.
- **Priority:** `rst` > `clr` > normal operation.
- **Reset / clear values:** state=IDLE, bit counter=0, shift reg=0, `data_out`=0, `data_vld`=0, `frm_err`=0, `ovr`=0, `busy`=0.
- **IDLE:**
  - strobe with `ser_in`=0: go to DATA, counter=0, shift reg=0.
  - strobe with `ser_in`=1: ignored.
- **DATA:** on each strobe, shift reg <= {shift reg[WIDTH-2:0], `ser_in`} and counter += 1. After the strobe taken at counter=WIDTH-1, go to STOP.
- **STOP, strobe with `ser_in`=1 (good frame):**
  - If `data_vld`=0, or `ack`=1 on the same edge: `data_out` <= shift reg and `data_vld` <= 1.
  - Otherwise: the word is dropped and `ovr` <= 1.
  - In both cases return to IDLE.
- **STOP, strobe with `ser_in`=0:** `frm_err` pulses for one cycle, the word is discarded, and the block returns to IDLE. `data_out` and `data_vld` are untouched.
- **Handshake:**
  - `ack`=1 while `data_vld`=1 clears `data_vld` and `ovr` on that edge, unless a good frame lands on the same edge (load wins; `data_vld` stays 1).
  - `ack` while `data_vld`=0 has no effect.
- **No strobe:** cycles with `ser_en`=0 hold state, counter and shift reg. There is no timeout.
- **Counter:** width $clog2(WIDTH). It never wraps inside a frame; it is reset on each start bit.

## Timing
- All outputs are registered.
- `data_vld` rises on the edge that samples the good stop bit. The word is visible in the cycle after that strobe.
- With `ser_en` held high, the word is valid WIDTH+2 cycles after the start-bit strobe edge (18 for WIDTH=16).
- `frm_err` is high for exactly the one cycle following the bad-stop-bit edge.
- `busy` goes high the cycle after the start-bit edge and low the cycle after the stop-bit edge.
- The next start bit may be sampled on the strobe immediately after the stop bit. There are no dead cycles.
- **Mid-frame `rst`/`clr`:** the partial word is discarded, no flag is raised, and the block returns to IDLE immediately (`rst`) or at the next edge (`clr`).

## Structure
- **Shared package `serial_pkg`:**
  - state enum IDLE/DATA/STOP.
  - `SER_WIDTH`=16.
  - `START_BIT`=1'b0 and `STOP_BIT`=1'b1.
  - frame length constant `SER_WIDTH`+2.
- **Sub-module `sipo_register`:** WIDTH-bit serial-in/parallel-out shift-left register. Inputs: `clk`, `rst`, `clr`, `sh_en`, `s_in`. Output: `q`. It is the receive-side counterpart of the transmit shift register. The top block holds the FSM, the counter, the output register and the flags.

## Test plan
- Frame 0, A5C3 MSB first, 1 with `ser_en`=1 every cycle -> `data_out`=16'hA5C3 and `data_vld`=1 exactly 18 cycles after the start edge, `frm_err`=0.
- Same frame with `ser_en` toggling 1-of-3 cycles and idle-high bits before start -> `data_out`=16'hA5C3, no spurious start.
- Frame 16'h1234 with stop bit 0 -> `frm_err` one-cycle pulse, `data_vld` stays 0, `data_out` unchanged (0).
- Two good frames 16'hFFFF then 16'h0001 with no `ack` -> `data_out`=16'hFFFF and `ovr`=1. Then `ack` -> `data_vld`=0, `ovr`=0. A third frame 16'h0001 with `ack` asserted on its stop edge -> `data_out`=16'h0001, `data_vld`=1, `ovr`=0.
- `rst` pulsed after 8 data bits of 16'hBEEF, then full frame 16'h8001 -> `data_out`=16'h8001, no `frm_err`/`ovr`. Repeat using `clr` -> same result.
